// File: rtl/td_sync_gen.sv
`timescale 1ns/1ps
// td_sync_gen: NTSC/PAL composite-style HS/VS timing generator with pixel/line counters and active-video flag.
// Latency: every output is registered from next-state counters, so HS/VS/ACTIVE are cycle-aligned with oH_CNT/oV_CNT.
// Backpressure: none; free-running while iEN=1, idle (counters 0, syncs high) while iEN=0. Interlace via TD_SYNC_INTERLACE_EN.
module td_sync_gen #(
  parameter int H_TOTAL_NTSC  = 858,
  parameter int H_TOTAL_PAL   = 864,
  parameter int H_SYNC        = 64,
  parameter int H_ACT_START   = 128,
  parameter int H_ACT         = 720,
  parameter int V_TOTAL_NTSC  = 262,
  parameter int V_TOTAL_PAL   = 312,
  parameter int VS_LINES_NTSC = 6,
  parameter int VS_LINES_PAL  = 24,
  parameter int V_ACT_START   = 26,
  parameter int V_ACT_NTSC    = 234,
  parameter int V_ACT_PAL     = 284
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iEN,
  input  logic       iPAL,
  output logic       oTD_HS,
  output logic       oTD_VS,
  output logic [9:0] oH_CNT,
  output logic [8:0] oV_CNT,
  output logic       oFIELD,
  output logic       oACTIVE,
  output logic       oPAL_ACT
);

  // Sized copies of the timing parameters so every compare is unsigned and width-matched.
  localparam logic [9:0] HT_N     = 10'(H_TOTAL_NTSC);
  localparam logic [9:0] HT_P     = 10'(H_TOTAL_PAL);
  localparam logic [9:0] HS_W     = 10'(H_SYNC);
  localparam logic [9:0] HA_START = 10'(H_ACT_START);
  localparam logic [9:0] HA_END   = 10'(H_ACT_START + H_ACT);
  localparam logic [8:0] VT_N     = 9'(V_TOTAL_NTSC);
  localparam logic [8:0] VT_P     = 9'(V_TOTAL_PAL);
  localparam logic [8:0] VSL_N    = 9'(VS_LINES_NTSC);
  localparam logic [8:0] VSL_P    = 9'(VS_LINES_PAL);
  localparam logic [8:0] VA_START = 9'(V_ACT_START);
  localparam logic [8:0] VA_END_N = 9'(V_ACT_START + V_ACT_NTSC);
  localparam logic [8:0] VA_END_P = 9'(V_ACT_START + V_ACT_PAL);

  // IDLE: held off by iEN=0 or fresh out of reset; the next enabled edge starts at pixel 0, line 0.
  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t     state, state_nxt;
  logic [9:0] h_nxt;
  logic [8:0] v_nxt;
  logic       field_nxt;
  logic       mode_nxt;
  logic       hs_nxt, vs_nxt, act_nxt;

  logic [9:0] ht_last;
  logic [8:0] vt_base;
  logic [8:0] vt_last;
  logic       line_end;
  logic       field_end;
  logic [8:0] vsl_nxt;
  logic [8:0] va_end_nxt;

  // Wrap points for the mode (and field parity) currently being generated.
  always_comb begin
    ht_last = (oPAL_ACT ? HT_P : HT_N) - 10'd1;
    vt_base = oPAL_ACT ? VT_P : VT_N;
`ifdef TD_SYNC_INTERLACE_EN
    // Odd field carries the extra line that makes a 525/625-line frame.
    vt_last = oFIELD ? vt_base : vt_base - 9'd1;
`else
    vt_last = vt_base - 9'd1;
`endif
    line_end  = (oH_CNT == ht_last);
    field_end = line_end && (oV_CNT == vt_last);
  end

  // Next-state counters, field parity and mode; the mode only reloads while idle or at the field wrap.
  always_comb begin
    state_nxt = ST_IDLE;
    h_nxt     = 10'd0;
    v_nxt     = 9'd0;
    field_nxt = 1'b0;
    mode_nxt  = iPAL;
    if (iEN) begin
      state_nxt = ST_RUN;
      if (state == ST_RUN) begin
        mode_nxt  = oPAL_ACT;
        field_nxt = oFIELD;
        h_nxt     = line_end ? 10'd0 : oH_CNT + 10'd1;
        if (field_end) begin
          v_nxt    = 9'd0;
          mode_nxt = iPAL;
`ifdef TD_SYNC_INTERLACE_EN
          field_nxt = ~oFIELD;
`endif
        end else begin
          v_nxt = line_end ? oV_CNT + 9'd1 : oV_CNT;
        end
      end
    end
  end

  // Output decodes from the next-state values, using the next mode so a new field starts with its own VSL/VA.
  always_comb begin
    vsl_nxt    = mode_nxt ? VSL_P : VSL_N;
    va_end_nxt = mode_nxt ? VA_END_P : VA_END_N;
    if (state_nxt == ST_RUN) begin
      hs_nxt  = (h_nxt >= HS_W);
      vs_nxt  = (v_nxt >= vsl_nxt);
      act_nxt = (h_nxt >= HA_START) && (h_nxt < HA_END) &&
                (v_nxt >= VA_START) && (v_nxt < va_end_nxt);
    end else begin
      hs_nxt  = 1'b1;
      vs_nxt  = 1'b1;
      act_nxt = 1'b0;
    end
  end

  // Single state register for the generator; reset forces the idle/sync-high values immediately.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state    <= ST_IDLE;
      oH_CNT   <= 10'd0;
      oV_CNT   <= 9'd0;
      oFIELD   <= 1'b0;
      oPAL_ACT <= 1'b0;
      oTD_HS   <= 1'b1;
      oTD_VS   <= 1'b1;
      oACTIVE  <= 1'b0;
    end else begin
      state    <= state_nxt;
      oH_CNT   <= h_nxt;
      oV_CNT   <= v_nxt;
      oFIELD   <= field_nxt;
      oPAL_ACT <= mode_nxt;
      oTD_HS   <= hs_nxt;
      oTD_VS   <= vs_nxt;
      oACTIVE  <= act_nxt;
    end
  end

endmodule

// File: tb/tb_td_sync_gen.sv
`timescale 1ns/1ps
// Bench for td_sync_gen: randomized enable/mode/reset stimulus against a cycle-position reference model,
// plus a loopback VS-width detector and per-field active-pixel totals. Uses scaled timing parameters so
// complete fields fit in a short run; VS widths stay at 6/24 lines so detector classification is realistic.
module tb_td_sync_gen;

  localparam int HTN = 58, HTP = 64, HSY = 8, HAS = 12, HACT = 40;
  localparam int VTN = 40, VTP = 48, VSLN = 6, VSLP = 24, VAS = 26, VAN = 12, VAP = 20;
`ifdef TD_SYNC_INTERLACE_EN
  localparam bit IL = 1'b1;
`else
  localparam bit IL = 1'b0;
`endif

  logic       iCLK = 1'b0;
  logic       iRST, iEN, iPAL;
  logic       oTD_HS, oTD_VS, oFIELD, oACTIVE, oPAL_ACT;
  logic [9:0] oH_CNT;
  logic [8:0] oV_CNT;

  always #5 iCLK = ~iCLK;

  td_sync_gen #(
    .H_TOTAL_NTSC(HTN), .H_TOTAL_PAL(HTP), .H_SYNC(HSY), .H_ACT_START(HAS), .H_ACT(HACT),
    .V_TOTAL_NTSC(VTN), .V_TOTAL_PAL(VTP), .VS_LINES_NTSC(VSLN), .VS_LINES_PAL(VSLP),
    .V_ACT_START(VAS), .V_ACT_NTSC(VAN), .V_ACT_PAL(VAP)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iEN(iEN), .iPAL(iPAL),
    .oTD_HS(oTD_HS), .oTD_VS(oTD_VS), .oH_CNT(oH_CNT), .oV_CNT(oV_CNT),
    .oFIELD(oFIELD), .oACTIVE(oACTIVE), .oPAL_ACT(oPAL_ACT)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Reference model: position within the field as a plain cycle count.
  bit m_run, m_mode, m_fld;
  int m_t;

  function automatic int ht(bit m);  return m ? HTP : HTN;   endfunction
  function automatic int vt(bit m, bit f); return (m ? VTP : VTN) + ((IL && f) ? 1 : 0); endfunction
  function automatic int vsl(bit m); return m ? VSLP : VSLN; endfunction
  function automatic int va(bit m);  return m ? VAP : VAN;   endfunction

  function automatic logic [31:0] idle_outs(bit m);
    return {8'd0, 1'b1, 1'b1, 10'd0, 9'd0, 1'b0, 1'b0, m};
  endfunction

  function automatic logic [31:0] exp_outs();
    int h, v;
    logic hs, vs, act;
    if (!m_run) return idle_outs(m_mode);
    h   = m_t % ht(m_mode);
    v   = m_t / ht(m_mode);
    hs  = (h >= HSY);
    vs  = (v >= vsl(m_mode));
    act = (h >= HAS) && (h < HAS + HACT) && (v >= VAS) && (v < VAS + va(m_mode));
    return {8'd0, hs, vs, 10'(h), 9'(v), m_fld, act, m_mode};
  endfunction

  function automatic logic [31:0] obs_outs();
    return {8'd0, oTD_HS, oTD_VS, oH_CNT, oV_CNT, oFIELD, oACTIVE, oPAL_ACT};
  endfunction

  // Detector classification: 1 = NTSC, 2 = PAL, 0 = unknown.
  function automatic int classify(int cnt);
    if (cnt >= 4 && cnt <= 14) return 1;
    if (cnt >= 20 && cnt <= 31) return 2;
    return 0;
  endfunction

  logic prev_hs = 1'b1, prev_vs = 1'b1;
  int   det_cnt = 0;
  int   act_cnt = 0;
  bit   fld_clean = 1'b0;
  bit   fld_mode = 1'b0;

  // One clock: advance the model on the rising edge, compare on the falling edge.
  task automatic step();
    @(posedge iCLK);
    if (!iEN) begin
      m_run = 1'b0; m_t = 0; m_fld = 1'b0; m_mode = iPAL;
    end else if (!m_run) begin
      m_run = 1'b1; m_t = 0; m_fld = 1'b0; m_mode = iPAL;
    end else begin
      m_t++;
      if (m_t == ht(m_mode) * vt(m_mode, m_fld)) begin
        m_t    = 0;
        m_fld  = IL ? !m_fld : 1'b0;
        m_mode = iPAL;
      end
    end
    @(negedge iCLK);
    chk("outs", obs_outs(), exp_outs());
    // Loopback detector: HS rising edges counted while VS is low.
    if (prev_vs && !oTD_VS) det_cnt = 0;
    if (!prev_vs && oTD_VS && m_run) begin
      chk("vs_edges", 32'(det_cnt), 32'(vsl(m_mode)));
      chk("detect_class", 32'(classify(det_cnt)), m_mode ? 32'd2 : 32'd1);
    end
    if (!oTD_VS && !prev_hs && oTD_HS) det_cnt++;
    // Active-pixel total over each complete field.
    if (!m_run) fld_clean = 1'b0;
    if (m_run && m_t == 0) begin
      if (fld_clean) chk("act_total", 32'(act_cnt), 32'(HACT * va(fld_mode)));
      act_cnt   = 0;
      fld_clean = 1'b1;
      fld_mode  = m_mode;
    end
    if (oACTIVE) act_cnt++;
    prev_hs = oTD_HS;
    prev_vs = oTD_VS;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Advance until the model sits at pixel 0 of the given line (bounded).
  task automatic run_to_line(input int line);
    for (int i = 0; i < 8000; i++) begin
      if (m_run && (m_t % ht(m_mode) == 0) && (m_t / ht(m_mode) == line)) return;
      step();
    end
    chk("reach_line_timeout", 32'd1, 32'd0);
  endtask

  // Advance until the next rising edge is the field wrap (bounded).
  task automatic run_to_last_pixel();
    for (int i = 0; i < 8000; i++) begin
      if (m_run && m_t == ht(m_mode) * vt(m_mode, m_fld) - 1) return;
      step();
    end
    chk("reach_wrap_timeout", 32'd1, 32'd0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must drop to reset values before any clock edge.
  task automatic do_reset();
    #2 iRST = 1'b1;
    #1 chk("rst_async", obs_outs(), idle_outs(1'b0));
    m_run = 1'b0; m_mode = 1'b0; m_t = 0; m_fld = 1'b0;
    prev_hs = 1'b1; prev_vs = 1'b1; fld_clean = 1'b0; act_cnt = 0; det_cnt = 0;
    @(negedge iCLK);
    chk("rst_hold", obs_outs(), idle_outs(1'b0));
    iRST = 1'b0;
  endtask

  initial begin
    int n;
    iRST = 1'b1; iEN = 1'b1; iPAL = 1'b0;
    m_run = 1'b0; m_mode = 1'b0; m_t = 0; m_fld = 1'b0;
    #3 chk("rst_init", obs_outs(), idle_outs(1'b0));
    @(negedge iCLK);
    iRST = 1'b0;

    // NTSC from reset: first cycle, then two full fields.
    step();
    chk("first_h", 32'(oH_CNT), 32'd0);
    chk("first_hs", 32'(oTD_HS), 32'd0);
    chk("first_vs", 32'(oTD_VS), 32'd0);
    run(2 * HTN * VTN + 20);

    // Mid-field switch to PAL; current field finishes as NTSC.
    run_to_line(20);
    iPAL = 1'b1;
    run_to_last_pixel();
    chk("pal_before_wrap", 32'(oPAL_ACT), 32'd0);
    step();
    chk("pal_after_wrap", 32'(oPAL_ACT), 32'd1);
    run(2 * HTP * (VTP + 1) + 20);

    // Disable mid-field, then restart.
    run_to_line(30);
    run(17);
    iEN = 1'b0;
    step();
    chk("dis_h", 32'(oH_CNT), 32'd0);
    chk("dis_v", 32'(oV_CNT), 32'd0);
    chk("dis_hs", 32'(oTD_HS), 32'd1);
    run(5);
    iEN = 1'b1;
    step();
    chk("reen_v", 32'(oV_CNT), 32'd0);
    chk("reen_field", 32'(oFIELD), 32'd0);
    run(HTP * VTP + 10);

    // Disable landing exactly on the field wrap.
    run_to_last_pixel();
    iEN = 1'b0;
    step();
    chk("dis_at_wrap_vs", 32'(oTD_VS), 32'd1);
    iEN = 1'b1;
    run(300);

    // Reset mid-line, then come back up in NTSC.
    run(37);
    do_reset();
    iPAL = 1'b0;
    run(HTN * VTN + 10);

    // Randomized enable, mode and reset activity.
    for (int k = 0; k < 12; k++) begin
      iPAL = 1'($urandom);
      iEN  = ($urandom % 5) != 0;
      n    = $urandom_range(50, 2400);
      run(n / 2);
      if ($urandom % 2 == 1) iPAL = ~iPAL;
      if ($urandom % 6 == 0) do_reset();
      run(n - n / 2);
    end
    iEN = 1'b1;
    run(HTP * (VTP + 1) * 2 + 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
